// File: rtl/fact_bin2bcd.sv
// Sequential 16-bit binary to 5-digit packed BCD converter (double-dabble, one bit per clock)
// with valid/ready handshakes on both the input and output sides.
module fact_bin2bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] bcd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sreg_q, sreg_d;
    logic [19:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic        out_valid_q, out_valid_d;

    logic [19:0] acc_corr;
    logic [35:0] shifted;

    // Add-3 correction on every nibble before the shift so each digit carries correctly.
    always_comb begin
        acc_corr = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {acc_corr, sreg_q} << 1;
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = bin;
                    acc_d   = 20'd0;
                    cnt_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d  = shifted[35:16];
                sreg_d = shifted[15:0];
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    bcd_d       = shifted[35:16];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= 16'd0;
            acc_q       <= 20'd0;
            cnt_q       <= 5'd0;
            bcd_q       <= 20'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_fact_bin2bcd.sv
// Randomized self-checking bench for fact_bin2bcd; expected digits come from plain
// decimal arithmetic on the input value.
module tb_fact_bin2bcd;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_accept = 0;

    fact_bin2bcd dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        r = 20'd0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge after the output handshake.
    task automatic applyStimulus(input logic [15:0] v, input int hold, input logic chk_gap,
                                 input logic mid_en, input logic [15:0] mid_bin);
        int k;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        if (chk_gap) checkOutput("accept_gap", 32'(cyc - prev_accept), 32'd18);
        prev_accept = cyc;
        bin       = v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        if (mid_en) begin
            bin = mid_bin;
        end else begin
            in_valid = 1'b0;
            bin = 16'($urandom);
        end
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("latency", 32'(k), 32'd16);
        checkOutput("bcd", 32'(bcd), 32'(ref_bcd(int'(v))));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_bcd", 32'(bcd), 32'(ref_bcd(int'(v))));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_valid", 32'(out_valid), 32'd0);
        checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bcd", 32'(bcd), 32'd0);

        applyStimulus(16'd0, 0, 1'b0, 1'b1, 16'd0);
        applyStimulus(16'd120, 0, 1'b1, 1'b0, 16'd0);
        applyStimulus(16'd5040, 0, 1'b1, 1'b0, 16'd0);
        applyStimulus(16'd40320, 0, 1'b1, 1'b0, 16'd0);

        applyStimulus(16'd65535, 0, 1'b0, 1'b0, 16'd0);
        applyStimulus(16'd9, 0, 1'b0, 1'b0, 16'd0);
        applyStimulus(16'd10, 0, 1'b0, 1'b0, 16'd0);
        applyStimulus(16'd9999, 0, 1'b0, 1'b0, 16'd0);

        applyStimulus(16'd720, 10, 1'b0, 1'b0, 16'd0);

        applyStimulus(16'd24, 0, 1'b0, 1'b1, 16'd999);
        applyStimulus(16'd999, 0, 1'b1, 1'b0, 16'd0);

        // Abandon a conversion of 362 partway through the shift phase.
        bin      = 16'd362;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_bcd", 32'(bcd), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_pulse", 32'(seen), 32'd0);
        applyStimulus(16'd6, 0, 1'b0, 1'b0, 16'd0);

        for (int n = 0; n < 25; n++) begin
            applyStimulus(16'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fact_bin2bcd.md
# fact_bin2bcd

Sequential binary-to-BCD converter that sits directly downstream of the factorial stage. It takes the 16-bit factorial result and produces five packed BCD digits for display or reporting. Conversion uses the iterative shift-and-add-3 (double-dabble) method, one bit per clock. Valid/ready handshakes on both sides let it sit between a producer and a consumer that may stall.

## Interface

Parameters:
- none. Widths are fixed: 16-bit binary in, 5 BCD digits out.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bin holds a value to convert.
- in_ready  output  1  block can accept a new value; equals (state == IDLE).
- bin  input  16  unsigned binary value (factorial result).
- out_valid  output  1  bcd holds a completed conversion.
- out_ready  input  1  consumer accepts bcd this cycle.
- bcd  output  20  packed BCD; [19:16] = ten-thousands digit … [3:0] = units digit.

## Operation

- Internal registers:
  - state: IDLE, SHIFT, DONE.
  - sreg[15:0]: input shift register.
  - acc[19:0]: BCD working accumulator.
  - cnt[4:0]: bit counter.
  - bcd[19:0]: output register.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: sreg<=bin, acc<=0, cnt<=0, state->SHIFT.
  - Otherwise hold.
- SHIFT, each cycle:
  - For each of the 5 nibbles of acc, if nibble ≥ 5, add 3 to it. All nibbles are corrected in parallel, within the same nibble.
  - Then {acc, sreg} <= {acc_corrected, sreg} << 1, so the MSB of sreg enters acc[0].
  - cnt <= cnt+1.
  - When cnt == 15 (the 16th shift): the bcd register loads the shifted result in that same edge, out_valid<=1, state->DONE.
- DONE:
  - out_valid=1 and bcd is stable.
  - On out_ready: out_valid<=0, state->IDLE.
  - Otherwise hold indefinitely. Backpressure never corrupts bcd.
- bcd keeps its last completed value through IDLE and SHIFT. It changes only at a completion edge.
- Arithmetic: the full input range 0–65535 maps to 00000–65535. The top digit never exceeds 6. No overflow condition exists.
- in_valid is ignored outside IDLE. bin is sampled only on the accept edge, so upstream may change bin afterward.
- out_ready is ignored outside DONE.

## Timing

- Reset (rst high at a rising edge):
  - state=IDLE, out_valid=0, bcd=0, acc=0, sreg=0, cnt=0.
  - in_ready reads 1 from the first cycle after reset.
  - Handshakes are ignored while rst=1.
- Reset mid-SHIFT or in DONE: the conversion is abandoned and no out_valid pulse is produced. Outputs take their reset values in the next cycle.
- Latency: with accept at edge E0, out_valid rises after edge E16. That is 16 cycles from accept to result.
- Throughput: with out_ready held at 1, one result every 18 cycles.
  - 1 accept cycle in IDLE.
  - 16 SHIFT cycles.
  - 1 DONE cycle.
- in_ready is 0 from the cycle after accept until the cycle after the DONE handshake. There is no bypass: a new input cannot be accepted in the same cycle as out_ready.
- Simultaneous rst and any handshake: reset wins.
- out_valid is purely registered. in_ready is a combinational decode of state only, with no combinational path from any input to any output.

## Test plan

- Reset, then bin=0 with in_valid held high → in_ready drops after accept; out_valid rises exactly 16 cycles after accept with bcd=20'h00000.
- Factorial values back-to-back, out_ready=1:
  - bin=120 (5!) → bcd=20'h00120.
  - bin=5040 (7!) → bcd=20'h05040.
  - bin=40320 (8!) → bcd=20'h40320.
  - Successive accepts are 18 cycles apart.
- Boundary values:
  - bin=65535 → 20'h65535.
  - bin=9 → 20'h00009.
  - bin=10 → 20'h00010.
  - bin=9999 → 20'h09999.
- Backpressure: bin=720 with out_ready=0 for 10 cycles after out_valid → out_valid and bcd=20'h00720 held stable throughout; in_ready=0 throughout; out_ready=1 → out_valid=0 and in_ready=1 next cycle.
- Input change after accept: accept bin=24, then drive bin=999 with in_valid=1 during SHIFT → result 20'h00024. 999 is accepted only once back in IDLE and yields 20'h00999.
- Reset at cycle 8 of a conversion of bin=362 → no out_valid pulse; bcd=0 and in_ready=1 after reset; the next conversion of bin=6 → 20'h00006.
